// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN feature-map datapath.
package cnn_pkg;

    typedef logic [7:0] pixel_t;

    localparam int BEATS_PER_WINDOW = 4;
    localparam int PIXELS_PER_WORD  = 4;

    typedef logic [$clog2(BEATS_PER_WINDOW)-1:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(BEATS_PER_WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } ofm_state_e;

endpackage

// File: rtl/ofm_window_reader_if.sv
// Window-row stream from the OFM reader to the layer-2 window buffer.
interface ofm_window_reader_if #(
    parameter int KERNEL_COUNT = 2
);
    import cnn_pkg::*;

    logic                                           valid;
    logic                                           ready;
    pixel_t [KERNEL_COUNT-1:0][PIXELS_PER_WORD-1:0] data;
    beat_t                                          beat;
    logic                                           last;

    modport master (output valid, data, beat, last, input ready);
    modport slave  (input valid, data, beat, last, output ready);

endinterface

// File: rtl/ofm_skid_fifo.sv
// Two-entry FIFO holding returned OFM words together with their row-in-window index.
module ofm_skid_fifo
    import cnn_pkg::*;
#(
    parameter int KERNEL_COUNT = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           push,
    input  pixel_t [KERNEL_COUNT-1:0][PIXELS_PER_WORD-1:0] push_data,
    input  beat_t                                          push_beat,
    input  logic                                           pop,
    output logic                                           pop_valid,
    output pixel_t [KERNEL_COUNT-1:0][PIXELS_PER_WORD-1:0] pop_data,
    output beat_t                                          pop_beat,
    output logic [1:0]                                     count
);

    pixel_t [KERNEL_COUNT-1:0][PIXELS_PER_WORD-1:0] mem_data [2];
    beat_t                                          mem_beat [2];
    logic                                           wr_ptr;
    logic                                           rd_ptr;

    // NOTE: the payload array is not reset; pointers and count define what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_beat[wr_ptr] <= push_beat;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        pop_valid = (count != 2'd0);
        pop_data  = '0;
        pop_beat  = '0;
        if (pop_valid) begin
            pop_data = mem_data[rd_ptr];
            pop_beat = mem_beat[rd_ptr];
        end
    end

endmodule

// File: rtl/ofm_window_reader.sv
// Walks the layer-1 OFM store in window order and streams 4-row windows to layer 2,
// hiding the one-cycle store latency and absorbing consumer backpressure.
module ofm_window_reader
    import cnn_pkg::*;
#(
    parameter int KERNEL_COUNT = 2,
    parameter int ROWS         = 43,
    parameter int COLS         = 4,
    parameter int STRIDE       = 1,
    parameter int ADDR_W       = $clog2(ROWS * COLS)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    output logic                                           rd_en,
    output logic [ADDR_W-1:0]                              rd_addr,
    input  pixel_t [KERNEL_COUNT-1:0][PIXELS_PER_WORD-1:0] rd_data,
    ofm_window_reader_if.master                            ofm,
    output logic                                           busy,
    output logic                                           done
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - BEATS_PER_WINDOW);
    localparam logic [ROW_W-1:0] ROW_STEP = ROW_W'(STRIDE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    ofm_state_e        state_q;
    ofm_state_e        state_d;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    beat_t             beat_q;
    logic              inflight_q;
    beat_t             inflight_beat_q;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              last_issue;
    logic [2:0]        credit_used;

    assign pop         = ofm.valid && ofm.ready;
    assign last_issue  = (row_q == ROW_LAST) && (col_q == COL_LAST) && (beat_q == LAST_BEAT);
    // Words already committed downstream once this cycle's pop is taken into account.
    assign credit_used = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign rd_addr     = ADDR_W'((int'(row_q) + int'(beat_q)) * COLS + int'(col_q));
    assign ofm.last    = (ofm.beat == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                busy  = 1'b1;
                rd_en = (credit_used < 3'd2);
                if (rd_en && last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!inflight_q && fifo_count == 2'(pop)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            row_q           <= '0;
            col_q           <= '0;
            beat_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_beat_q <= '0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= rd_en;
            inflight_beat_q <= beat_q;
            if (state_q == IDLE && start) begin
                row_q  <= '0;
                col_q  <= '0;
                beat_q <= '0;
            end else if (rd_en && !last_issue) begin
                beat_q <= beat_q + beat_t'(1);
                if (beat_q == LAST_BEAT) begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + ROW_STEP;
                    end else begin
                        col_q <= col_q + COL_W'(1);
                    end
                end
            end
        end
    end

    ofm_skid_fifo #(
        .KERNEL_COUNT (KERNEL_COUNT)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rd_data),
        .push_beat (inflight_beat_q),
        .pop       (pop),
        .pop_valid (ofm.valid),
        .pop_data  (ofm.data),
        .pop_beat  (ofm.beat),
        .count     (fifo_count)
    );

endmodule

// File: doc/ofm_window_reader.md
# ofm_window_reader

Read-side sequencer for the layer-1 output feature map (OFM) store. Layer 1 fills that store one address per cycle. Each word holds 4 pixels per kernel at `wr_ofm_addr`. This block walks the store in window order and streams 4-beat windows (4 rows × 4 pixels per kernel) to the layer-2 window buffer over a valid/ready handshake. It owns address generation, the read-latency pipeline and backpressure. It does not own the storage.

## Interface
- `KERNEL_COUNT`, 2: number of kernels (feature-map channels) per word.
- `ROWS`, 43: OFM rows.
- `COLS`, 4: words per OFM row. `ROWS*COLS` = 172 store entries.
- `STRIDE`, 1: vertical window stride. Must satisfy `(ROWS-4) % STRIDE == 0`.
- `ADDR_W`, `$clog2(ROWS*COLS)`: store address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin one frame traversal. Sampled only in IDLE.
- `rd_en`, out, 1: store read strobe.
- `rd_addr`, out, `ADDR_W`: store read address. Valid when `rd_en`=1.
- `rd_data`, in, 8 × [`KERNEL_COUNT`][4]: store word. Valid exactly one cycle after `rd_en`.
- `out_valid`, out, 1: `out_data` holds a beat.
- `out_ready`, in, 1: consumer accepts the beat this cycle.
- `out_data`, out, 8 × [`KERNEL_COUNT`][4]: one window row for all kernels.
- `out_beat`, out, 2: row index 0..3 within the current window.
- `out_last`, out, 1: high when `out_beat`==3.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse after the final beat of the frame is accepted.

## Operation
- Traversal order:
  - Window base row `r` = 0, STRIDE, …, ROWS-4 (outer loop).
  - Column `c` = 0..COLS-1 (middle loop).
  - Beat `b` = 0..3 (inner loop).
  - `rd_addr` = (r+b)·COLS + c.
  - Windows per frame: ((ROWS-4)/STRIDE+1)·COLS. Defaults give 160 windows, 640 beats.
- FSM:
  - IDLE: on `start`, go to FETCH and clear the counters.
  - FETCH: issue reads under the credit rule. After issuing the last address, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- Buffering: a 2-entry FIFO holds returned words. `rd_data` is written into the FIFO at the end of the cycle it is valid. `out_beat` travels through the FIFO alongside the data.
- Credit rule: `rd_en` = FETCH ∧ (fifo_count + inflight − pop < 2). `pop` = `out_valid` ∧ `out_ready`. The combinational `out_ready`→`rd_en` path is intended.
- Overflow and loss: the FIFO never overflows. No beat is duplicated or dropped under any `out_ready` pattern.
- `start` while not IDLE: ignored.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, counters 0. A reset mid-frame abandons the traversal. Data returning after reset is discarded.
- Counter wrap: `c` wraps COLS-1→0 while `r` advances by STRIDE. After the last beat of r = ROWS-4, c = COLS-1, address issue stops. The counters do not wrap into the next frame.

## Timing
- `start` high in IDLE at cycle 0 produces:
  - `busy`=1 and `rd_en`=1 with `rd_addr`=0 at cycle 1.
  - `rd_data` valid at cycle 2.
  - `out_valid`=1 at cycle 3.
- With `out_ready` held high: one beat per cycle, no bubbles. Frame completes in beats+3 cycles. `done` appears the cycle after the last accept.
- With `out_ready` low: at most 2 words are buffered or in flight. `rd_en` stalls until a pop occurs.
- `out_data`, `out_beat` and `out_last` stay stable while `out_valid` ∧ ¬`out_ready`.

## Structure
- Shared package `cnn_pkg`:
  - `pixel_t` (logic [7:0]).
  - `BEATS_PER_WINDOW`=4.
  - `ofm_state_e` {IDLE, FETCH, DRAIN, DONE}.
- One sub-module, `ofm_skid_fifo`: 2-entry FIFO carrying {data, beat} with count output. Address counters and FSM live in the top.

## Test plan
- Reset: assert `rst`=0 mid-frame (cycle 50). Expect all outputs 0 next cycle, no `done`. A new `start` restarts from `rd_addr`=0.
- First window, defaults: `start`, `out_ready`=1. Expect `rd_addr` 0,4,8,12 then 1,5,9,13. Expect `out_beat` 0,1,2,3 with `out_last` on beat 3. First `out_valid` at cycle 3.
- Full frame, defaults: 640 beats in 643 cycles. Last `rd_addr`=171. `done` pulses once. A store model checks every word.
- Backpressure: random `out_ready` at 30%. Expect an identical beat sequence to the full-frame test and (fifo_count+inflight) ≤ 2 always.
- Small config ROWS=6, COLS=2, STRIDE=2: expect 4 windows, 16 beats. Address sequence is 0,2,4,6, 1,3,5,7, 4,6,8,10, 5,7,9,11.
- `start` pulsed while busy at cycle 20: expect no restart and the frame to complete unchanged.
